// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - attention core sequencer: loads Q/K rows, then steps feed/execute/drain/write/accumulate/divide.
// Outputs are registered images of the state of the previous cycle; din_ready follows the current state.
module core_ctrl #(
  parameter int bw    = 8,
  parameter int pr    = 16,
  parameter int col   = 8,
  parameter int DRAIN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       num_rows,
  input  logic [pr*bw-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [20:0]      inst,
  output logic [pr*bw-1:0] mem_in,
  output logic             busy,
  output logic             done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] COL_L   = CW'(col);
  localparam logic [CW-1:0] DRAIN_L = CW'(DRAIN);

  localparam int B_DIV   = 20;
  localparam int B_OFIFO = 16;
  localparam int B_EXEC  = 7;
  localparam int B_LOAD  = 6;
  localparam int B_QRD   = 5;
  localparam int B_QWR   = 4;
  localparam int B_KRD   = 3;
  localparam int B_KWR   = 2;
  localparam int B_PRD   = 1;
  localparam int B_PWR   = 0;

  typedef enum logic [3:0] {
    S_IDLE, S_QLOAD, S_KLOAD, S_KFEED, S_EXEC,
    S_DRAIN, S_OWR, S_ACC, S_DIV, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    n_q, n_nx;
  logic [CW-1:0] n_ext;
  logic [20:0]   inst_nx;
  logic          mem_ld;

  assign n_ext = CW'(n_q);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    n_nx      = n_q;
    inst_nx   = '0;
    mem_ld    = 1'b0;
    din_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_nx     = (num_rows == 4'd0) ? 5'd16 : {1'b0, num_rows};
          cnt_nx   = '0;
          state_nx = S_QLOAD;
        end
      end
      S_QLOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          inst_nx[B_QWR]   = 1'b1;
          inst_nx[15:12]   = cnt[3:0];
          mem_ld           = 1'b1;
          if (cnt == n_ext - CW'(1)) begin
            cnt_nx   = '0;
            state_nx = S_KLOAD;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      S_KLOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          inst_nx[B_KWR]   = 1'b1;
          inst_nx[15:12]   = cnt[3:0];
          mem_ld           = 1'b1;
          if (cnt == COL_L - CW'(1)) begin
            cnt_nx   = '0;
            state_nx = S_KFEED;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      // Read and its consumer overlap by one cycle to cover the SRAM read latency.
      S_KFEED: begin
        if (cnt < COL_L) begin
          inst_nx[B_KRD]   = 1'b1;
          inst_nx[15:12]   = cnt[3:0];
        end
        inst_nx[B_LOAD] = (cnt != '0);
        if (cnt == COL_L) begin
          cnt_nx   = '0;
          state_nx = S_EXEC;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_EXEC: begin
        if (cnt < n_ext) begin
          inst_nx[B_QRD]   = 1'b1;
          inst_nx[15:12]   = cnt[3:0];
        end
        inst_nx[B_EXEC] = (cnt != '0);
        if (cnt == n_ext) begin
          cnt_nx   = '0;
          state_nx = S_DRAIN;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_L - CW'(1)) begin
          cnt_nx   = '0;
          state_nx = S_OWR;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_OWR, S_ACC, S_DIV: begin
        if (state == S_OWR) begin
          inst_nx[B_OFIFO] = 1'b1;
          inst_nx[B_PWR]   = 1'b1;
          inst_nx[11:8]    = cnt[3:0];
        end else if (state == S_ACC) begin
          inst_nx[B_PRD]   = 1'b1;
          inst_nx[11:8]    = cnt[3:0];
        end else begin
          inst_nx[B_DIV]   = 1'b1;
        end
        if (cnt == n_ext - CW'(1)) begin
          cnt_nx   = '0;
          state_nx = (state == S_OWR) ? S_ACC : (state == S_ACC) ? S_DIV : S_DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      n_q    <= '0;
      inst   <= '0;
      mem_in <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      n_q   <= n_nx;
      inst  <= inst_nx;
      if (mem_ld) mem_in <= din;
      busy  <= (state != S_IDLE);
      done  <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - randomized bench for core_ctrl against a script-based sequence model.
module tb_core_ctrl;
  localparam int BW = 8, PR = 16, COL = 8, DR = 16, W = PR * BW;

  logic          clk = 1'b0;
  logic          reset, start, din_valid, din_ready, busy, done;
  logic [3:0]    num_rows;
  logic [W-1:0]  din, mem_in;
  logic [20:0]   inst;

  always #5 clk = ~clk;

  core_ctrl #(.bw(BW), .pr(PR), .col(COL), .DRAIN(DR)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .inst(inst), .mem_in(mem_in), .busy(busy), .done(done)
  );

  int tests = 0, fails = 0;

  typedef struct packed {
    logic [20:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t         script[$];
  int           m_mode = 0;  // 0 idle, 1 Q load, 2 K load, 3 scripted tail
  int           m_n, m_cnt, script_pos;
  logic [20:0]  e_inst = '0;
  logic [W-1:0] e_mem = '0;
  logic         e_busy = 0, e_done = 0, e_ready = 0;

  int busy_cnt, done_cnt, qwr_cnt, q0_cnt, pwr_cnt, last_qaddr, last_paddr;
  logic [20:0] first_qwr;
  logic        seen_qwr;

  function automatic exp_t ent(input logic [20:0] w, input logic b, input logic d);
    exp_t e;
    e.inst = w; e.busy = b; e.done = d;
    return e;
  endfunction

  // Everything after the last K beat is fixed given N.
  task automatic build_script();
    logic [20:0] w;
    script.delete();
    for (int j = 0; j <= COL; j++) begin
      w = '0;
      if (j < COL) begin w[3] = 1'b1; w[15:12] = j[3:0]; end
      if (j >= 1) w[6] = 1'b1;
      script.push_back(ent(w, 1'b1, 1'b0));
    end
    for (int j = 0; j <= m_n; j++) begin
      w = '0;
      if (j < m_n) begin w[5] = 1'b1; w[15:12] = j[3:0]; end
      if (j >= 1) w[7] = 1'b1;
      script.push_back(ent(w, 1'b1, 1'b0));
    end
    for (int j = 0; j < DR; j++) script.push_back(ent(21'h0, 1'b1, 1'b0));
    for (int j = 0; j < m_n; j++) begin
      w = '0; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = j[3:0];
      script.push_back(ent(w, 1'b1, 1'b0));
    end
    for (int j = 0; j < m_n; j++) begin
      w = '0; w[1] = 1'b1; w[11:8] = j[3:0];
      script.push_back(ent(w, 1'b1, 1'b0));
    end
    for (int j = 0; j < m_n; j++) begin
      w = '0; w[20] = 1'b1;
      script.push_back(ent(w, 1'b1, 1'b0));
    end
    script.push_back(ent(21'h0, 1'b1, 1'b1));
  endtask

  task automatic model_step(input logic rst, input logic st, input logic [3:0] nr,
                            input logic [W-1:0] d, input logic v);
    exp_t e;
    e_done = 1'b0;
    if (rst) begin
      m_mode = 0; script.delete();
      e_inst = '0; e_mem = '0; e_busy = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          e_inst = '0; e_busy = 1'b0;
          if (st) begin m_n = (nr == 4'd0) ? 16 : int'(nr); m_cnt = 0; m_mode = 1; end
        end
        1, 2: begin
          e_busy = 1'b1; e_inst = '0;
          if (v) begin
            e_inst[(m_mode == 1) ? 4 : 2] = 1'b1;
            e_inst[15:12] = m_cnt[3:0];
            e_mem = d;
            m_cnt++;
            if (m_mode == 1 && m_cnt == m_n) begin
              m_mode = 2; m_cnt = 0;
            end else if (m_mode == 2 && m_cnt == COL) begin
              m_mode = 3; build_script(); script_pos = 0;
            end
          end
        end
        default: begin
          e = script.pop_front();
          e_inst = e.inst; e_busy = e.busy; e_done = e.done;
          script_pos++;
          if (script.size() == 0) m_mode = 0;
        end
      endcase
    end
    e_ready = (m_mode == 1 || m_mode == 2);
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; qwr_cnt = 0; q0_cnt = 0; pwr_cnt = 0;
    last_qaddr = -1; last_paddr = -1; seen_qwr = 1'b0; first_qwr = '0;
  endtask

  task automatic lit(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic [3:0] nr, input logic v);
    reset = rst; start = st; num_rows = nr; din_valid = v;
    din = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    model_step(rst, st, nr, din, v);
    @(negedge clk);
    tests++;
    if ({inst, mem_in, busy, done, din_ready} !== {e_inst, e_mem, e_busy, e_done, e_ready}) begin
      fails++;
      $display("FAIL cycle t=%0t: inst %h want %h busy %b want %b done %b want %b rdy %b want %b mem %h want %h",
               $time, inst, e_inst, busy, e_busy, done, e_done, din_ready, e_ready, mem_in, e_mem);
    end
    tests++;
    if (inst[19:17] != 3'b000 || $countones(inst[5:0]) > 1) begin
      fails++;
      $display("FAIL invariant t=%0t: inst %h", $time, inst);
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (inst[4]) begin
      qwr_cnt++; last_qaddr = int'(inst[15:12]);
      if (inst[15:12] == 4'd0) q0_cnt++;
      if (!seen_qwr) begin seen_qwr = 1'b1; first_qwr = inst; end
    end
    if (inst[0]) begin pwr_cnt++; last_paddr = int'(inst[11:8]); end
  endtask

  task automatic run_seq(input int vmode, input int limit);
    int k;
    k = 0;
    while (m_mode != 0 && k < limit) begin
      cyc(1'b0, 1'b0, 4'($urandom), (vmode == 0) ? 1'b1 : (vmode == 1) ? (k % 2 == 0) : 1'($urandom));
      k++;
    end
    if (m_mode != 0) begin
      tests++; fails++;
      $display("FAIL timeout: sequence not finished after %0d cycles", limit);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_rows = '0; din = '0; din_valid = 1'b0;
    clear_stats();
    repeat (3) cyc(1'b1, 1'b0, 4'd0, 1'b0);
    lit("reset_busy", int'(busy), 0);
    lit("reset_inst", int'(inst), 0);
    lit("reset_mem", int'(mem_in != '0), 0);
    lit("reset_ready", int'(din_ready), 0);

    cyc(1'b1, 1'b1, 4'd8, 1'b1);
    cyc(1'b0, 1'b0, 4'd8, 1'b1);
    lit("reset_beats_start", int'(busy | din_ready), 0);

    clear_stats();
    cyc(1'b0, 1'b1, 4'd8, 1'b1);
    run_seq(0, 300);
    lit("n8_busy_cycles", busy_cnt, 75);
    lit("n8_done", done_cnt, 1);
    lit("n8_qwr", qwr_cnt, 8);
    lit("n8_last_qaddr", last_qaddr, 7);
    lit("n8_first_inst", int'(first_qwr), 'h00010);

    clear_stats();
    cyc(1'b0, 1'b1, 4'd5, 1'b0);
    run_seq(1, 300);
    lit("toggle_qwr", qwr_cnt, 5);
    lit("toggle_done", done_cnt, 1);

    clear_stats();
    cyc(1'b0, 1'b1, 4'd0, 1'b0);
    run_seq(2, 600);
    lit("n16_qwr", qwr_cnt, 16);
    lit("n16_last_qaddr", last_qaddr, 15);
    lit("n16_addr0_once", q0_cnt, 1);
    lit("n16_pwr", pwr_cnt, 16);
    lit("n16_last_paddr", last_paddr, 15);

    clear_stats();
    cyc(1'b0, 1'b1, 4'd4, 1'b1);
    for (int k = 0; k < 200 && !(m_mode == 3 && script_pos == COL + 4); k++)
      cyc(1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b1, 1'b0, 4'd0, 1'b1);
    lit("exec_reset_busy", int'(busy), 0);
    lit("exec_reset_inst", int'(inst), 0);
    lit("exec_reset_done", done_cnt, 0);
    clear_stats();
    cyc(1'b0, 1'b1, 4'd4, 1'b1);
    run_seq(0, 300);
    lit("rerun_qwr", qwr_cnt, 4);
    lit("rerun_done", done_cnt, 1);

    clear_stats();
    cyc(1'b0, 1'b1, 4'd3, 1'b1);
    for (int k = 0; k < 200 && !(m_mode == 3 && script_pos == COL + 1 + 4 + 2); k++)
      cyc(1'b0, 1'b0, 4'd0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 4'd9, 1'b1);
    run_seq(0, 300);
    repeat (4) cyc(1'b0, 1'b0, 4'd0, 1'b1);
    lit("drain_start_done", done_cnt, 1);

    for (int k = 0; k < 3000; k++)
      cyc(($urandom % 200) == 0, ($urandom % 6) == 0, 4'($urandom), 1'($urandom));
    run_seq(2, 600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
